pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the CPU pipeline, the successor to the fixed-field inter-stage latches. It carries an opaque payload bundle between any two stages with a valid/ready handshake, synchronous flush for bubble insertion, and an optional two-entry skid buffer. The skid buffer lets backpressure be registered rather than combinational. One instance sits on each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 52 +++++
 rtl/pipe_stage_skid.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
// Contents:
//   state_t    - occupancy state of a stage register (EMPTY / ONE / FULL)
//   BUBBLE     - fill bit for an empty slot; slots are cleared to all-BUBBLE
//   *_W        - payload widths for each stage boundary
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Replicated to the payload width wherever a slot is emptied.
  localparam logic BUBBLE = 1'b0;

  // Payload widths per boundary.
  // IF/ID : PC + instruction word.
  // ID/EX : r1, r2, rd, imm, PC, op_data, ALU_command.
  // EX/MEM: ALU result, store data, rd and memory control.
  // MEM/WB: writeback value, rd and writeback control.
  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 153;
  localparam int EXMEM_W = 106;
  localparam int MEMWB_W = 70;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage register: payload plus valid bit.
// Ports:
//   clk_en   - clock
//   rst      - asynchronous active-low reset (slot emptied, data zeroed)
//   load_i   - capture d_i and mark the slot valid
//   clear_i  - empty the slot and zero its data (wins over load_i)
//   d_i      - payload to capture
//   valid_o  - slot holds a beat
//   data_o   - held payload, zero whenever valid_o is low
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_W
) (
  input  logic              clk_en,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] d_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = {DATA_W{BUBBLE}};
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end
  end

  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_W{BUBBLE}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer. One instance per stage boundary.
// Parameters:
//   DATA_W - payload width
//   SKID   - 1: main + skid slot, in_ready registered
//            0: main slot only, in_ready = !out_valid || out_ready
// Ports:
//   clk_en    - clock
//   rst       - asynchronous active-low reset, discards all beats
//   in_valid  - upstream offers a beat
//   in_ready  - stage accepts a beat this cycle
//   in_data   - upstream payload
//   flush     - synchronous kill of all held beats and of the offered beat
//   out_valid - downstream beat presented (main slot valid)
//   out_ready - downstream accepts the beat
//   out_data  - main slot payload, zero when out_valid is low
//   occupancy - beats held (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_en,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_t            state_q, state_d;
  logic              in_xfer, out_xfer;

  logic              main_load, main_clr;
  logic [DATA_W-1:0] main_d;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;

  logic              skid_load, skid_clr;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  // With the skid slot, in_ready comes straight from the state register so
  // out_ready never reaches it combinationally.
  assign in_ready = SKID ? (state_q != FULL) : (!main_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  // State register
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) state_d = ONE;
        ONE: begin
          // Without a skid slot, in_xfer in ONE implies out_xfer.
          if (in_xfer && !out_xfer)      state_d = SKID ? FULL : ONE;
          else if (out_xfer && !in_xfer) state_d = EMPTY;
        end
        FULL:    if (out_xfer) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Slot control
  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      // A handshake in this cycle is still consumed downstream; nothing replays.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: main_load = in_xfer;
        ONE: begin
          if (in_xfer && out_xfer) main_load = 1'b1;
          else if (in_xfer)        skid_load = 1'b1;
          else if (out_xfer)       main_clr  = 1'b1;
        end
        FULL: begin
          if (out_xfer) begin
            main_load = 1'b1;
            main_d    = skid_data;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk_en  (clk_en),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clr),
    .d_i     (main_d),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W)) u_skid (
        .clk_en  (clk_en),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .d_i     (in_data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
      );
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = {DATA_W{BUBBLE}};
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W = IDEX_W;

  logic clk_en = 1'b0;
  logic rst    = 1'b0;
  always #5 clk_en = ~clk_en;

  // SKID=1 instance
  logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  // SKID=0 instance
  logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;

  pipe_stage_skid #(.DATA_W(W), .SKID(1'b1)) dut_a (
    .clk_en(clk_en), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(W), .SKID(1'b0)) dut_b (
    .clk_en(clk_en), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled 1 time unit later.
  task automatic step();
    @(posedge clk_en);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [W-1:0] d,
                       input logic [1:0] occ, input logic rdy);
    chk({tag, ".a_out_valid"}, a_out_valid, v);
    chk({tag, ".a_out_data"},  a_out_data,  d);
    chk({tag, ".a_occ"},       a_occ,       occ);
    chk({tag, ".a_in_ready"},  a_in_ready,  rdy);
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [W-1:0] d,
                       input logic [1:0] occ, input logic rdy);
    chk({tag, ".b_out_valid"}, b_out_valid, v);
    chk({tag, ".b_out_data"},  b_out_data,  d);
    chk({tag, ".b_occ"},       b_occ,       occ);
    chk({tag, ".b_in_ready"},  b_in_ready,  rdy);
  endtask

  initial begin
    a_in_valid = 0; a_in_data = '0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_flush = 0; b_out_ready = 0;

    // Reset state
    #3;
    chk_a("reset", 1'b0, '0, 2'd0, 1'b1);
    chk_b("reset", 1'b0, '0, 2'd0, 1'b1);
    #9 rst = 1'b1;

    // Single beat, latency 1
    a_in_valid = 1; a_in_data = W'(8'hA5); a_out_ready = 1;
    step();
    chk_a("single", 1'b1, W'(8'hA5), 2'd1, 1'b1);
    a_in_valid = 0;
    step();
    chk_a("drain_bubble", 1'b0, '0, 2'd0, 1'b1);

    // Back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = W'(i);
      step();
      chk_a($sformatf("stream%0d", i), 1'b1, W'(i), 2'd1, 1'b1);
    end
    a_in_valid = 0;
    step();
    chk_a("stream_end", 1'b0, '0, 2'd0, 1'b1);

    // Backpressure into the skid slot
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = W'(8'h10);
    step();
    chk_a("bp_10", 1'b1, W'(8'h10), 2'd1, 1'b1);
    a_in_data = W'(8'h11);
    step();
    chk_a("bp_11", 1'b1, W'(8'h10), 2'd2, 1'b0);
    a_in_data = W'(8'h12);
    step();
    chk_a("bp_hold12", 1'b1, W'(8'h10), 2'd2, 1'b0);
    a_out_ready = 1;
    step();
    chk_a("bp_out11", 1'b1, W'(8'h11), 2'd1, 1'b1);
    step();
    chk_a("bp_out12", 1'b1, W'(8'h12), 2'd1, 1'b1);
    a_in_valid = 0;
    step();
    chk_a("bp_empty", 1'b0, '0, 2'd0, 1'b1);

    // Flush at occupancy 2 with a beat offered
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = W'(8'h21);
    step();
    a_in_data = W'(8'h22);
    step();
    chk_a("fl_full", 1'b1, W'(8'h21), 2'd2, 1'b0);
    a_in_data = W'(8'h33); a_flush = 1;
    step();
    chk_a("fl_after", 1'b0, '0, 2'd0, 1'b1);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    step();
    chk_a("fl_no33", 1'b0, '0, 2'd0, 1'b1);

    // Asynchronous reset mid-operation
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = W'(8'h51);
    step();
    a_in_data = W'(8'h52);
    step();
    chk_a("ar_full", 1'b1, W'(8'h51), 2'd2, 1'b0);
    a_in_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk_a("ar_now", 1'b0, '0, 2'd0, 1'b1);
    step();
    rst = 1'b1;
    a_in_valid = 1; a_in_data = W'(8'h44); a_out_ready = 1;
    step();
    chk_a("ar_44", 1'b1, W'(8'h44), 2'd1, 1'b1);
    a_in_valid = 0;
    step();
    chk_a("ar_alone", 1'b0, '0, 2'd0, 1'b1);

    // SKID=0: combinational in_ready and in-place replacement
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = W'(8'h61);
    step();
    chk_b("s0_61", 1'b1, W'(8'h61), 2'd1, 1'b0);
    b_out_ready = 1; b_in_data = W'(8'h62);
    #1;
    chk("s0_rdy_comb", b_in_ready, 1'b1);
    step();
    chk_b("s0_62", 1'b1, W'(8'h62), 2'd1, 1'b1);
    b_out_ready = 0; b_in_data = W'(8'h63);
    step();
    chk_b("s0_hold", 1'b1, W'(8'h62), 2'd1, 1'b0);
    b_in_valid = 0; b_out_ready = 1;
    step();
    chk_b("s0_drain", 1'b0, '0, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
